// File: rtl/interrupt_sequencer.sv
// Interrupt/reset entry sequencer: pushes PC and P to the stack, then fetches the
// service vector, arbitrating between RST, edge-latched NMI, level IRQs and BRK.
module interrupt_sequencer #(
    parameter int                ADDR_W     = 16,
    parameter int                NUM_IRQ    = 1,
    parameter logic [ADDR_W-9:0] STACK_PAGE = 'h01,
    parameter logic [ADDR_W-1:0] VEC_NMI    = 'hFFFA,
    parameter logic [ADDR_W-1:0] VEC_RST    = 'hFFFC,
    parameter logic [ADDR_W-1:0] VEC_IRQ    = 'hFFFE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               nmi,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               brk,
    input  logic               insn_done,
    input  logic               rdy,
    input  logic               P_i,
    input  logic [7:0]         S,
    output logic               busy,
    output logic [ADDR_W-1:0]  addr_out,
    output logic               mem_rw,
    output logic [1:0]         data_sel,
    output logic               b_flag,
    output logic               S_dec,
    output logic               PCL_ld,
    output logic               PCH_ld,
    output logic               PI_ld,
    output logic               nmi_ack,
    output logic [NUM_IRQ-1:0] irq_ack
);

    typedef enum logic [2:0] {
        S_IDLE, S_PUSH_H, S_PUSH_L, S_PUSH_P, S_VEC_L, S_VEC_H
    } state_t;

    typedef enum logic [1:0] {
        K_RST, K_NMI, K_IRQ, K_BRK
    } kind_t;

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [2:0]  irq_idx_q, irq_idx_d;
    logic        nmi_prev_q, nmi_prev_d;
    logic        nmi_pend_q, nmi_pend_d;

    logic        nmi_edge;
    logic        take_nmi;
    logic        irq_hit;
    logic [2:0]  irq_sel;
    logic        strobe_en;
    logic        ack_en;
    logic [ADDR_W-1:0] vec_addr;

    // Lowest-index unmasked IRQ wins; the loop runs high-to-low so the last hit sticks.
    always_comb begin
        irq_hit = 1'b0;
        irq_sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq[i] && !P_i) begin
                irq_hit = 1'b1;
                irq_sel = 3'(i);
            end
        end
    end

    always_comb begin
        nmi_prev_d = nmi;
        nmi_edge   = nmi & ~nmi_prev_q;
        state_d    = state_q;
        kind_d     = kind_q;
        irq_idx_d  = irq_idx_q;
        take_nmi   = 1'b0;
        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (insn_done) begin
                        if (nmi_pend_q) begin
                            kind_d   = K_NMI;
                            state_d  = S_PUSH_H;
                            take_nmi = 1'b1;
                        end else if (irq_hit) begin
                            kind_d    = K_IRQ;
                            irq_idx_d = irq_sel;
                            state_d   = S_PUSH_H;
                        end else if (brk) begin
                            kind_d  = K_BRK;
                            state_d = S_PUSH_H;
                        end
                    end
                end
                S_PUSH_H: state_d = S_PUSH_L;
                S_PUSH_L: state_d = S_PUSH_P;
                S_PUSH_P: state_d = S_VEC_L;
                S_VEC_L:  state_d = S_VEC_H;
                S_VEC_H:  state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
        // A fresh edge in the cycle the pending NMI is taken must not be lost.
        nmi_pend_d = nmi_edge | (nmi_pend_q & ~take_nmi);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_PUSH_H;
            kind_q     <= K_RST;
            irq_idx_q  <= '0;
            nmi_prev_q <= 1'b1;
            nmi_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            irq_idx_q  <= irq_idx_d;
            nmi_prev_q <= nmi_prev_d;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    always_comb begin
        case (kind_q)
            K_RST:   vec_addr = VEC_RST;
            K_NMI:   vec_addr = VEC_NMI;
            K_IRQ:   vec_addr = VEC_IRQ - ADDR_W'({irq_idx_q, 2'b00});
            default: vec_addr = VEC_IRQ;
        endcase
    end

    // Bus outputs follow the state; strobes are suppressed while stalled or in reset.
    always_comb begin
        busy      = (state_q != S_IDLE);
        strobe_en = rdy & ~rst;
        addr_out  = '0;
        mem_rw    = 1'b1;
        data_sel  = 2'd0;
        S_dec     = 1'b0;
        PCL_ld    = 1'b0;
        PCH_ld    = 1'b0;
        PI_ld     = 1'b0;
        nmi_ack   = 1'b0;
        ack_en    = 1'b0;
        case (state_q)
            S_PUSH_H, S_PUSH_L, S_PUSH_P: begin
                addr_out = {STACK_PAGE, S};
                mem_rw   = (kind_q == K_RST);
                S_dec    = strobe_en;
                if (state_q == S_PUSH_L) data_sel = 2'd1;
                if (state_q == S_PUSH_P) data_sel = 2'd2;
            end
            S_VEC_L: begin
                addr_out = vec_addr;
                PCL_ld   = strobe_en;
                PI_ld    = strobe_en;
            end
            S_VEC_H: begin
                addr_out = vec_addr + ADDR_W'(1);
                PCH_ld   = strobe_en;
                ack_en   = strobe_en;
                nmi_ack  = strobe_en & (kind_q == K_NMI);
            end
            default: ;
        endcase
        b_flag = busy & (kind_q == K_BRK);
    end

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_ack
            assign irq_ack[gi] = ack_en & (kind_q == K_IRQ) & (irq_idx_q == 3'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench: stimulus pushes expected bus cycles, a negedge monitor pops and compares.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst, nmi, brk, insn_done, rdy, P_i;
    logic [3:0]  irq;
    logic [7:0]  S;
    logic        busy, mem_rw, b_flag, S_dec, PCL_ld, PCH_ld, PI_ld, nmi_ack;
    logic [15:0] addr_out;
    logic [1:0]  data_sel;
    logic [3:0]  irq_ack;

    interrupt_sequencer #(.ADDR_W(16), .NUM_IRQ(4)) dut (
        .clk(clk), .rst(rst), .nmi(nmi), .irq(irq), .brk(brk),
        .insn_done(insn_done), .rdy(rdy), .P_i(P_i), .S(S),
        .busy(busy), .addr_out(addr_out), .mem_rw(mem_rw), .data_sel(data_sel),
        .b_flag(b_flag), .S_dec(S_dec), .PCL_ld(PCL_ld), .PCH_ld(PCH_ld),
        .PI_ld(PI_ld), .nmi_ack(nmi_ack), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    // {addr[28:13], rw[12], sel[11:10], b[9], sdec[8], pcl[7], pch[6], pi[5], nack[4], iack[3:0]}
    typedef logic [28:0] bus_t;
    bus_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bus_t mk(input logic [15:0] a, input logic rw, input logic [1:0] sel,
                                input logic bf, input logic sd, input logic pcl, input logic pch,
                                input logic pi, input logic na, input logic [3:0] ia);
        return {a, rw, sel, bf, sd, pcl, pch, pi, na, ia};
    endfunction

    task automatic exp_seq(input logic [15:0] sa, input logic rd, input logic bf,
                           input logic [15:0] v, input logic na, input logic [3:0] ia);
        logic [15:0] v1;
        v1 = v + 16'd1;
        exp_q.push_back(mk(sa, rd, 2'd0, bf, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0));
        exp_q.push_back(mk(sa, rd, 2'd1, bf, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0));
        exp_q.push_back(mk(sa, rd, 2'd2, bf, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0));
        exp_q.push_back(mk(v,  1'b1, 2'd0, bf, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0));
        exp_q.push_back(mk(v1, 1'b1, 2'd0, bf, 1'b0, 1'b0, 1'b1, 1'b0, na, ia));
    endtask

    // Monitor: every unstalled busy cycle is one transaction to check.
    always @(negedge clk) begin
        bus_t a;
        bus_t e;
        a = {addr_out, mem_rw, data_sel, b_flag, S_dec, PCL_ld, PCH_ld, PI_ld, nmi_ack, irq_ack};
        if (!rst && busy) begin
            if (rdy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_cycle: got %h want none", a);
                end else begin
                    e = exp_q.pop_front();
                    $display("bus t=%0t addr=%h rw=%b sel=%0d b=%b sdec=%b pcl=%b pch=%b pi=%b nack=%b iack=%b",
                             $time, addr_out, mem_rw, data_sel, b_flag, S_dec, PCL_ld, PCH_ld,
                             PI_ld, nmi_ack, irq_ack);
                    chk("bus_cycle", 32'(a), 32'(e));
                end
            end else begin
                e = (exp_q.size() > 0) ? exp_q[0] : '0;
                $display("stall t=%0t addr=%h rw=%b sel=%0d", $time, addr_out, mem_rw, data_sel);
                chk("stall_hold", 32'(a[28:10]), 32'(e[28:10]));
                chk("stall_strobes", 32'(a[8:0]), 32'd0);
            end
        end
    end

    task automatic wait_idle(input int t0, input int lat, input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(name, cyc - t0, lat);
    endtask

    task automatic issue(input logic [3:0] irq_v, input logic brk_v, input logic pi_v,
                         input logic [7:0] s_v, output int t0);
        irq = irq_v; brk = brk_v; P_i = pi_v; S = s_v;
        insn_done = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        insn_done = 1'b0; irq = 4'b0; brk = 1'b0;
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_busy"}, busy, 1);
        chk({name, "_strobes"}, {S_dec, PCL_ld, PCH_ld, PI_ld, nmi_ack, irq_ack}, 0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst = 1'b1; nmi = 1'b0; irq = 4'b0; brk = 1'b0; insn_done = 1'b0;
        rdy = 1'b1; P_i = 1'b1; S = 8'hFD;

        // Reset entry: three dummy reads at 01FD then vector FFFC/FFFD.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state("rst");
        exp_seq(16'h01FD, 1'b1, 1'b0, 16'hFFFC, 1'b0, 4'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        t0 = cyc;
        wait_idle(t0, 5, "rst_seq_latency");

        // irq[0] with I clear.
        exp_seq(16'h01F0, 1'b0, 1'b0, 16'hFFFE, 1'b0, 4'b0001);
        issue(4'b0001, 1'b0, 1'b0, 8'hF0, t0);
        wait_idle(t0, 6, "irq0_latency");

        // irq[3:2] set: lowest index (2) wins, vector FFFE-8.
        exp_seq(16'h01F0, 1'b0, 1'b0, 16'hFFF6, 1'b0, 4'b0100);
        issue(4'b1100, 1'b0, 1'b0, 8'hF0, t0);
        wait_idle(t0, 6, "irq2_latency");

        // Latched NMI beats irq and brk at the same boundary.
        nmi = 1'b1;
        @(posedge clk); #1;
        exp_seq(16'h01F0, 1'b0, 1'b0, 16'hFFFA, 1'b1, 4'b0);
        issue(4'b0001, 1'b1, 1'b0, 8'hF0, t0);
        nmi = 1'b0;
        wait_idle(t0, 6, "nmi_latency");

        // The dropped brk is not remembered: a bare boundary starts nothing.
        issue(4'b0000, 1'b0, 1'b1, 8'hF0, t0);
        repeat (3) @(negedge clk);
        chk("brk_dropped_idle", busy, 0);

        // Three-cycle stall in PUSH_L.
        exp_seq(16'h01E0, 1'b0, 1'b0, 16'hFFFA, 1'b0, 4'b0010);
        issue(4'b0010, 1'b0, 1'b0, 8'hE0, t0);
        @(posedge clk); #1;
        rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy = 1'b1;
        wait_idle(t0, 9, "stall_latency");

        // BRK alone with I set: b_flag throughout, vector FFFE, no ack.
        exp_seq(16'h01C0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 4'b0);
        issue(4'b0001, 1'b1, 1'b1, 8'hC0, t0);
        wait_idle(t0, 6, "brk_latency");

        // NMI edge and a stray boundary during an IRQ sequence; NMI follows afterwards.
        exp_seq(16'h01B0, 1'b0, 1'b0, 16'hFFF2, 1'b0, 4'b1000);
        exp_seq(16'h01B0, 1'b0, 1'b0, 16'hFFFA, 1'b1, 4'b0);
        issue(4'b1000, 1'b0, 1'b0, 8'hB0, t0);
        nmi = 1'b1;
        @(posedge clk); #1;
        nmi = 1'b0; insn_done = 1'b1; brk = 1'b1;
        @(posedge clk); #1;
        insn_done = 1'b0; brk = 1'b0;
        wait_idle(t0, 6, "irq3_latency");
        issue(4'b0000, 1'b0, 1'b1, 8'hB0, t0);
        wait_idle(t0, 6, "late_nmi_latency");

        // Reset in PUSH_P aborts the sequence without an ack, then reset entry runs.
        exp_q.push_back(mk(16'h01A0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0));
        exp_q.push_back(mk(16'h01A0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0));
        issue(4'b0001, 1'b0, 1'b0, 8'hA0, t0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("abort");
        exp_seq(16'h01A0, 1'b1, 1'b0, 16'hFFFC, 1'b0, 4'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        t0 = cyc;
        wait_idle(t0, 5, "rst2_latency");

        repeat (2) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
